// File: rtl/debug_print_arb_pkg.sv
// Shared types and constants for the debug print arbiter.
// DEBUG_PRINT_ARB_PREFIX_EN adds the "<id>:" line-prefix states to the state enum.
`ifndef ASCII_WIDTH
`define ASCII_WIDTH 8
`endif

package debug_print_arb_pkg;

  localparam int unsigned N_REQ_DEF        = 4;
  localparam int unsigned FIFO_DEPTH_DEF   = 16;
  localparam int unsigned LINE_TIMEOUT_DEF = 256;

  localparam logic [`ASCII_WIDTH-1:0] NEWLINE = `ASCII_WIDTH'('h0A);
  localparam logic [`ASCII_WIDTH-1:0] COLON   = `ASCII_WIDTH'('h3A);
  localparam logic [`ASCII_WIDTH-1:0] DIGIT0  = `ASCII_WIDTH'('h30);

`ifdef DEBUG_PRINT_ARB_PREFIX_EN
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PFX_ID    = 2'd1,
    PFX_COLON = 2'd2,
    STREAM    = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd3
  } state_t;
`endif

endpackage

// File: rtl/debug_print_arbiter_fifo.sv
// Per-requester character FIFO: full/empty tracking, combinational head, drop pulse on push-to-full.
// Independent of DEBUG_PRINT_ARB_PREFIX_EN.
`ifndef ASCII_WIDTH
`define ASCII_WIDTH 8
`endif

module debug_print_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = `ASCII_WIDTH
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head_c,
  output logic             empty_c,
  output logic             drop_c
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic             full;
  logic             rd_en;
  logic             wr_en;

  assign empty_c = (wr_ptr == rd_ptr);
  assign full    = ((wr_ptr ^ rd_ptr) == {1'b1, {PW{1'b0}}});
  assign rd_en   = pop && !empty_c;
  // A pop in the same cycle frees the slot, so a push to a full FIFO still lands.
  assign wr_en   = push && (!full || rd_en);
  assign drop_c  = push && full && !rd_en;
  assign head_c  = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (rd_en) rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[PW-1:0]] <= din;
  end

endmodule

// File: rtl/debug_print_arbiter.sv
// Merges per-requester debug character streams onto one console sink, one whole line at a time.
// DEBUG_PRINT_ARB_PREFIX_EN prefixes every granted line with "<id>:".
`ifndef ASCII_WIDTH
`define ASCII_WIDTH 8
`endif

module debug_print_arbiter
  import debug_print_arb_pkg::*;
#(
  parameter int unsigned N_REQ        = N_REQ_DEF,
  parameter int unsigned FIFO_DEPTH   = FIFO_DEPTH_DEF,
  parameter int unsigned LINE_TIMEOUT = LINE_TIMEOUT_DEF
) (
  input  logic                                     clk,
  input  logic                                     res_n,
  input  logic [N_REQ-1:0]                         req_sig,
  input  logic [N_REQ*`ASCII_WIDTH-1:0]            req_ascii,
  output logic                                     out_valid,
  output logic [`ASCII_WIDTH-1:0]                  out_ascii,
  output logic [$clog2(N_REQ > 1 ? N_REQ : 2)-1:0] out_src,
  input  logic                                     out_ready,
  output logic [N_REQ-1:0]                         overflow,
  output logic                                     busy
);

  localparam int unsigned AW    = `ASCII_WIDTH;
  localparam int unsigned SRC_W = $clog2(N_REQ > 1 ? N_REQ : 2);
  localparam int unsigned TMO_W = $clog2(LINE_TIMEOUT + 1);

  state_t           state;
  logic [SRC_W-1:0] grant;
  logic [SRC_W-1:0] last_grant;
  logic [SRC_W-1:0] next_grant;
  logic [SRC_W-1:0] idx;
  logic [TMO_W-1:0] tmo_cnt;
  logic [N_REQ-1:0] empty;
  logic [N_REQ-1:0] drop;
  logic [N_REQ-1:0] pop;
  logic [AW-1:0]    head [N_REQ];
  logic [AW-1:0]    grant_head;
  logic             grant_empty;
  logic             grant_push;
  logic             any_req;
  logic             xfer;

  for (genvar i = 0; i < N_REQ; i++) begin : g_fifo
    debug_print_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (AW)
    ) u_fifo (
      .clk     (clk),
      .res_n   (res_n),
      .push    (req_sig[i]),
      .din     (req_ascii[i*AW +: AW]),
      .pop     (pop[i]),
      .head_c  (head[i]),
      .empty_c (empty[i]),
      .drop_c  (drop[i])
    );
  end

  assign grant_head  = head[grant];
  assign grant_empty = empty[grant];
  assign grant_push  = req_sig[grant];
  assign any_req     = ~&empty;
  assign xfer        = out_valid && out_ready;
  assign out_src     = grant;
  assign busy        = (state != IDLE) || any_req;

  // Round-robin pick starting after last_grant; the lowest offset found wins.
  always_comb begin
    next_grant = '0;
    idx        = '0;
    for (int k = int'(N_REQ); k >= 1; k--) begin
      idx = SRC_W'((int'(last_grant) + k) % int'(N_REQ));
      if (!empty[idx]) next_grant = idx;
    end
  end

  always_comb begin
    out_valid = 1'b0;
    out_ascii = '0;
    pop       = '0;
    unique case (state)
`ifdef DEBUG_PRINT_ARB_PREFIX_EN
      PFX_ID: begin
        out_valid = 1'b1;
        out_ascii = DIGIT0 + AW'(grant);
      end
      PFX_COLON: begin
        out_valid = 1'b1;
        out_ascii = COLON;
      end
`endif
      STREAM: begin
        out_valid = !grant_empty;
        out_ascii = grant_empty ? '0 : grant_head;
        pop[grant] = !grant_empty && out_ready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= SRC_W'(N_REQ - 1);
      tmo_cnt    <= '0;
      overflow   <= '0;
    end else begin
      overflow <= overflow | drop;
      unique case (state)
        IDLE: begin
          if (any_req) begin
            grant   <= next_grant;
            tmo_cnt <= '0;
`ifdef DEBUG_PRINT_ARB_PREFIX_EN
            state   <= PFX_ID;
`else
            state   <= STREAM;
`endif
          end
        end
`ifdef DEBUG_PRINT_ARB_PREFIX_EN
        PFX_ID:    if (xfer) state <= PFX_COLON;
        PFX_COLON: if (xfer) state <= STREAM;
`endif
        STREAM: begin
          if (xfer && grant_head == NEWLINE) begin
            state      <= IDLE;
            last_grant <= grant;
            tmo_cnt    <= '0;
          end else if (!grant_empty || grant_push) begin
            tmo_cnt <= '0;
          end else if (tmo_cnt == TMO_W'(LINE_TIMEOUT - 1)) begin
            // Requester went quiet mid-line: release the console to the others.
            state      <= IDLE;
            last_grant <= grant;
            tmo_cnt    <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_print_arbiter.sv
// Self-checking bench for debug_print_arbiter: queue-based line model compared every cycle plus literal line checks.
// Honours DEBUG_PRINT_ARB_PREFIX_EN when the build defines it.
`ifndef ASCII_WIDTH
`define ASCII_WIDTH 8
`endif

module tb_debug_print_arbiter;

  localparam int N     = 4;
  localparam int DEPTH = 16;
  localparam int LT    = 256;
`ifdef DEBUG_PRINT_ARB_PREFIX_EN
  localparam int PFX_LEN = 2;
`else
  localparam int PFX_LEN = 0;
`endif

  logic         clk = 1'b0;
  logic         res_n;
  logic [N-1:0] req_sig;
  logic [N*8-1:0] req_ascii;
  logic         out_valid;
  logic [7:0]   out_ascii;
  logic [1:0]   out_src;
  logic         out_ready;
  logic [N-1:0] overflow;
  logic         busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  logic mon_en = 1'b0;

  // Model state: one queue per requester plus the current line owner.
  logic [7:0] mq [N][$];
  int owner, phase, last, msrc, tmo;
  logic [N-1:0] movf;
  logic e_valid, e_busy;
  logic [7:0] e_ascii;

  int logq[$];
  int logcyc[$];
  int expq[$];

  debug_print_arbiter u_dut (
    .clk       (clk),
    .res_n     (res_n),
    .req_sig   (req_sig),
    .req_ascii (req_ascii),
    .out_valid (out_valid),
    .out_ascii (out_ascii),
    .out_src   (out_src),
    .out_ready (out_ready),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic calc_exp();
    e_valid = 1'b0;
    e_ascii = 8'h00;
    e_busy  = (owner >= 0);
    for (int i = 0; i < N; i++) if (mq[i].size() > 0) e_busy = 1'b1;
    if (owner >= 0) begin
      if (phase == 0) begin
        e_valid = 1'b1;
        e_ascii = 8'(8'h30 + owner);
      end else if (phase == 1) begin
        e_valid = 1'b1;
        e_ascii = 8'h3A;
      end else if (mq[owner].size() > 0) begin
        e_valid = 1'b1;
        e_ascii = mq[owner][0];
      end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) mq[i].delete();
    owner = -1;
    phase = 2;
    last  = N - 1;
    msrc  = 0;
    tmo   = 0;
    movf  = '0;
  endtask

  task automatic model_step();
    logic xfer;
    logic [7:0] c;
    bit found;
    calc_exp();
    xfer = e_valid && out_ready;
    if (owner < 0) begin
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        int j;
        j = (last + k) % N;
        if (!found && mq[j].size() > 0) begin
          found = 1'b1;
          owner = j;
          msrc  = j;
          phase = (PFX_LEN > 0) ? 0 : 2;
          tmo   = 0;
        end
      end
    end else if (phase < 2) begin
      if (xfer) phase++;
    end else if (xfer) begin
      c = mq[owner].pop_front();
      tmo = 0;
      if (c == 8'h0A) begin
        last  = owner;
        owner = -1;
      end
    end else if (mq[owner].size() > 0 || req_sig[owner]) begin
      tmo = 0;
    end else begin
      tmo++;
      if (tmo == LT) begin
        last  = owner;
        owner = -1;
        tmo   = 0;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (req_sig[i]) begin
        if (mq[i].size() < DEPTH) mq[i].push_back(req_ascii[8*i +: 8]);
        else movf[i] = 1'b1;
      end
    end
  endtask

  always @(posedge clk or negedge res_n) begin
    if (!res_n) model_reset();
    else model_step();
  end

  // Mid-cycle compare of every output against the model, plus a log of transfers.
  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      calc_exp();
      chk("valid", out_valid, e_valid);
      if (e_valid) chk("ascii", out_ascii, e_ascii);
      chk("src", out_src, msrc);
      chk("ovf", overflow, movf);
      chk("busy", busy, e_busy);
      if (out_valid && out_ready) begin
        logq.push_back(int'(out_src) * 256 + int'(out_ascii));
        logcyc.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic strobe(input logic [N-1:0] mask, input logic [N*8-1:0] chars);
    req_sig   = mask;
    req_ascii = chars;
    tick();
    req_sig   = '0;
    req_ascii = '0;
  endtask

  task automatic send_str(input int r, input string s);
    for (int i = 0; i < s.len(); i++) strobe(N'(1 << r), 32'(s[i]) << (8 * r));
  endtask

  task automatic exp_line(input int src, input string s);
    if (PFX_LEN > 0) begin
      expq.push_back(src * 256 + 'h30 + src);
      expq.push_back(src * 256 + 'h3A);
    end
    for (int i = 0; i < s.len(); i++) expq.push_back(src * 256 + int'(s[i]));
  endtask

  task automatic wait_idle(input int max_cyc);
    int n = 0;
    while (busy !== 1'b0 && n < max_cyc) begin
      tick();
      n++;
    end
    chk("wait_idle", busy, 1'b0);
  endtask

  task automatic cmp_log(input string name);
    chk({name, "_len"}, logq.size(), expq.size());
    for (int i = 0; i < logq.size() && i < expq.size(); i++) chk(name, logq[i], expq[i]);
  endtask

  task automatic clear_log();
    logq.delete();
    logcyc.delete();
    expq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    res_n = 1'b0; req_sig = '0; req_ascii = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_ascii", out_ascii, 8'h00);
    chk("rst_src", out_src, 2'd0);
    chk("rst_ovf", overflow, 4'h0);
    chk("rst_busy", busy, 1'b0);
    res_n = 1'b1;
    mon_en = 1'b1;
    tick();

    // Requester 2 prints "hi\n"; valid rises two cycles after the first strobe.
    out_ready = 1'b1;
    clear_log();
    strobe(4'b0100, 32'h68 << 16);
    chk("lat_t1", out_valid, 1'b0);
    strobe(4'b0100, 32'h69 << 16);
    chk("lat_t2", out_valid, 1'b1);
    chk("lat_src", out_src, 2'd2);
    strobe(4'b0100, 32'h0A << 16);
    wait_idle(40);
    exp_line(2, "hi\n");
    cmp_log("hi_seq");

    // Requesters 0 and 1 print "ab\n" in lockstep; lines must not interleave.
    clear_log();
    strobe(4'b0011, 32'h6161);
    strobe(4'b0011, 32'h6262);
    strobe(4'b0011, 32'h0A0A);
    wait_idle(60);
    exp_line(0, "ab\n");
    exp_line(1, "ab\n");
    cmp_log("ab_seq");

    // Stalled sink, 17 pushes to requester 3: last one dropped and flagged.
    out_ready = 1'b0;
    clear_log();
    for (int k = 0; k < DEPTH + 1; k++) begin
      strobe(4'b1000, 32'(8'h41 + k) << 24);
      if (k == DEPTH - 1) chk("ovf_before", overflow, 4'h0);
    end
    chk("ovf_after", overflow, 4'h8);
    repeat (5) tick();
    chk("stall_valid", out_valid, 1'b1);
    chk("stall_ascii", out_ascii, (PFX_LEN > 0) ? 8'h33 : 8'h41);
    out_ready = 1'b1;
    wait_idle(400);
    exp_line(3, "ABCDEFGHIJKLMNOP");
    cmp_log("drain_seq");

    // Requester 1 leaves a line open; timeout hands the console to requester 0.
    clear_log();
    strobe(4'b0010, 32'h78 << 8);
    strobe(4'b0001, 32'h79);
    strobe(4'b0001, 32'h0A);
    wait_idle(400);
    exp_line(1, "x");
    exp_line(0, "y\n");
    cmp_log("tmo_seq");
    if (logcyc.size() == expq.size())
      chk("tmo_gap", logcyc[2 * PFX_LEN + 1] - logcyc[PFX_LEN], LT + 2 + PFX_LEN);

    // Reset mid-line discards buffered text and restarts round-robin at requester 0.
    out_ready = 1'b0;
    clear_log();
    send_str(2, "abc");
    tick();
    #1 res_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_ascii", out_ascii, 8'h00);
    chk("arst_src", out_src, 2'd0);
    chk("arst_ovf", overflow, 4'h0);
    chk("arst_busy", busy, 1'b0);
    tick();
    res_n = 1'b1;
    clear_log();
    out_ready = 1'b1;
    strobe(4'b0101, 32'h0071_007A);
    strobe(4'b0101, 32'h000A_000A);
    wait_idle(60);
    exp_line(0, "z\n");
    exp_line(2, "q\n");
    cmp_log("post_rst_seq");

    // Requester 1 prints "k\n" (prefixed "1:" when the prefix build is selected).
    clear_log();
    send_str(1, "k\n");
    wait_idle(40);
    exp_line(1, "k\n");
    cmp_log("k_seq");
    if (logq.size() > 0) chk("k_first", logq[0], (PFX_LEN > 0) ? 32'h131 : 32'h16B);

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
